// File: rtl/hpi_pkg.sv
`default_nettype none
// ============================================================================
// hpi_pkg : shared types and constants for the EZ-OTG HPI bus sequencer
// Revision: 1.0
// ============================================================================
package hpi_pkg;

  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 16;

  localparam logic [1:0] HPI_DATA    = 2'd0;
  localparam logic [1:0] HPI_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_ADDR    = 2'd2;
  localparam logic [1:0] HPI_STATUS  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RECOVER = 3'd4,
    ST_CHIPRST = 3'd5
  } hpi_state_t;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hpi_bus_sequencer_if.sv
`default_nettype none
// ============================================================================
// hpi_bus_sequencer_if : requester-side handshake bundle of the HPI sequencer
// Revision: 1.0
// ============================================================================
interface hpi_bus_sequencer_if;
  import hpi_pkg::*;

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0]             req_write;
  logic [NUM_REQ-1:0][1:0]        req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]             rsp_valid;
  logic [DATA_W-1:0]              rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface
`default_nettype wire

// File: rtl/hpi_rr_arbiter.sv
`default_nettype none
// ============================================================================
// hpi_rr_arbiter : 2-way round-robin grant with last-served pointer
// Revision: 1.0
// ============================================================================
module hpi_rr_arbiter (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  logic r_last;

  // On a tie the requester not served last wins.
  always_comb begin
    gnt_valid = |req;
    if (req[0] && req[1]) gnt_idx = ~r_last;
    else                  gnt_idx = req[1];
  end

  // Reset to "1 served last" so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_last <= 1'b1;
    else if (accept) r_last <= gnt_idx;
  end

endmodule
`default_nettype wire

// File: rtl/hpi_bus_sequencer.sv
`default_nettype none
// ============================================================================
// hpi_bus_sequencer : timed HPI register access and chip-reset sequencer
// Revision: 1.0
// ============================================================================
module hpi_bus_sequencer
  import hpi_pkg::*;
#(
  parameter int SETUP_CYC   = 1,
  parameter int STROBE_CYC  = 3,
  parameter int HOLD_CYC    = 1,
  parameter int RECOVER_CYC = 2,
  parameter int RST_CYC     = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  hpi_bus_sequencer_if.slave bus,
  input  logic               chip_rst_req,
  output logic               busy,
  output logic [1:0]         otg_hpi_address,
  output logic               otg_hpi_cs_n,
  output logic               otg_hpi_r_n,
  output logic               otg_hpi_w_n,
  output logic               otg_hpi_reset_n,
  output logic [15:0]        otg_hpi_data_out,
  output logic               otg_hpi_data_oe,
  input  logic [15:0]        otg_hpi_data_in
);

  localparam int MAX_CYC = max_of(max_of(max_of(SETUP_CYC, STROBE_CYC),
                                         max_of(HOLD_CYC, RECOVER_CYC)), RST_CYC);
  localparam int CW = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] C_SETUP_LD   = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] C_STROBE_LD  = CW'(STROBE_CYC - 1);
  localparam logic [CW-1:0] C_HOLD_LD    = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] C_RECOVER_LD = CW'(RECOVER_CYC - 1);
  localparam logic [CW-1:0] C_RST_LD     = CW'(RST_CYC - 1);

  hpi_state_t       r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_rst_pend;
  logic             r_write;
  logic             r_owner;
  logic             w_rst_any;
  logic             w_gnt_valid;
  logic             w_gnt_idx;
  logic             w_accept;
  logic [1:0]       w_ready;

  hpi_rr_arbiter u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (bus.req_valid),
    .accept    (w_accept),
    .gnt_valid (w_gnt_valid),
    .gnt_idx   (w_gnt_idx)
  );

  // A pending chip reset (or one arriving this cycle) blocks all grants.
  assign w_rst_any = r_rst_pend | chip_rst_req;

  always_comb begin
    w_ready = '0;
    if (r_state == ST_IDLE && !w_rst_any && w_gnt_valid) w_ready[w_gnt_idx] = 1'b1;
  end

  assign bus.req_ready = w_ready;
  assign w_accept      = |(bus.req_valid & w_ready);
  assign busy          = (r_state != ST_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= ST_IDLE;
      r_cnt            <= '0;
      r_rst_pend       <= 1'b0;
      r_write          <= 1'b0;
      r_owner          <= 1'b0;
      otg_hpi_address  <= '0;
      otg_hpi_cs_n     <= 1'b1;
      otg_hpi_r_n      <= 1'b1;
      otg_hpi_w_n      <= 1'b1;
      otg_hpi_reset_n  <= 1'b1;
      otg_hpi_data_out <= '0;
      otg_hpi_data_oe  <= 1'b0;
      bus.rsp_valid    <= '0;
      bus.rsp_rdata    <= '0;
    end else begin
      bus.rsp_valid <= '0;
      if (chip_rst_req) r_rst_pend <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (w_rst_any) begin
            r_rst_pend      <= 1'b0;
            otg_hpi_reset_n <= 1'b0;
            r_cnt           <= C_RST_LD;
            r_state         <= ST_CHIPRST;
          end else if (w_accept) begin
            r_owner          <= w_gnt_idx;
            r_write          <= bus.req_write[w_gnt_idx];
            otg_hpi_address  <= bus.req_addr[w_gnt_idx];
            otg_hpi_data_out <= bus.req_write[w_gnt_idx] ? bus.req_wdata[w_gnt_idx] : '0;
            otg_hpi_data_oe  <= bus.req_write[w_gnt_idx];
            otg_hpi_cs_n     <= 1'b0;
            r_cnt            <= C_SETUP_LD;
            r_state          <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (r_cnt == '0) begin
            if (r_write) otg_hpi_w_n <= 1'b0;
            else         otg_hpi_r_n <= 1'b0;
            r_cnt   <= C_STROBE_LD;
            r_state <= ST_STROBE;
          end else r_cnt <= r_cnt - 1'b1;
        end
        ST_STROBE: begin
          if (r_cnt == '0) begin
            otg_hpi_r_n            <= 1'b1;
            otg_hpi_w_n            <= 1'b1;
            bus.rsp_rdata          <= r_write ? '0 : otg_hpi_data_in;
            bus.rsp_valid[r_owner] <= 1'b1;
            r_cnt                  <= C_HOLD_LD;
            r_state                <= ST_HOLD;
          end else r_cnt <= r_cnt - 1'b1;
        end
        ST_HOLD: begin
          if (r_cnt == '0) begin
            otg_hpi_cs_n     <= 1'b1;
            otg_hpi_data_oe  <= 1'b0;
            otg_hpi_data_out <= '0;
            r_cnt            <= C_RECOVER_LD;
            r_state          <= (RECOVER_CYC == 0) ? ST_IDLE : ST_RECOVER;
          end else r_cnt <= r_cnt - 1'b1;
        end
        ST_RECOVER: begin
          if (r_cnt == '0) r_state <= ST_IDLE;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        ST_CHIPRST: begin
          if (r_cnt == '0) begin
            otg_hpi_reset_n <= 1'b1;
            r_cnt           <= C_RECOVER_LD;
            r_state         <= (RECOVER_CYC == 0) ? ST_IDLE : ST_RECOVER;
          end else r_cnt <= r_cnt - 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hpi_bus_sequencer.sv
`default_nettype none
// ============================================================================
// tb_hpi_bus_sequencer : default-timing and zero-recovery instances vs an
// access-age reference model, with directed and random requester traffic
// Revision: 1.0
// ============================================================================
module tb_hpi_bus_sequencer;
  import hpi_pkg::*;

  localparam int S = 1, T = 3, H = 1, RSTC = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0][1:0]       v, wr;
  logic [1:0][1:0][1:0]  ad;
  logic [1:0][1:0][15:0] wd;
  logic [1:0]            crst;
  logic [15:0]           din;

  wire [1:0][1:0]  rdy, rv;
  wire [1:0][15:0] rd, dout;
  wire [1:0][1:0]  haddr;
  wire [1:0]       cs_n, r_n, w_n, hrst_n, oe, busy;

  hpi_bus_sequencer_if bus0 ();
  hpi_bus_sequencer_if bus1 ();

  assign bus0.req_valid = v[0];  assign bus1.req_valid = v[1];
  assign bus0.req_write = wr[0]; assign bus1.req_write = wr[1];
  assign bus0.req_addr  = ad[0]; assign bus1.req_addr  = ad[1];
  assign bus0.req_wdata = wd[0]; assign bus1.req_wdata = wd[1];
  assign rdy[0] = bus0.req_ready; assign rdy[1] = bus1.req_ready;
  assign rv[0]  = bus0.rsp_valid; assign rv[1]  = bus1.rsp_valid;
  assign rd[0]  = bus0.rsp_rdata; assign rd[1]  = bus1.rsp_rdata;

  hpi_bus_sequencer dut0 (
    .clk(clk), .reset_n(rst_n), .bus(bus0), .chip_rst_req(crst[0]), .busy(busy[0]),
    .otg_hpi_address(haddr[0]), .otg_hpi_cs_n(cs_n[0]), .otg_hpi_r_n(r_n[0]),
    .otg_hpi_w_n(w_n[0]), .otg_hpi_reset_n(hrst_n[0]), .otg_hpi_data_out(dout[0]),
    .otg_hpi_data_oe(oe[0]), .otg_hpi_data_in(din)
  );

  hpi_bus_sequencer #(.RECOVER_CYC(0)) dut1 (
    .clk(clk), .reset_n(rst_n), .bus(bus1), .chip_rst_req(crst[1]), .busy(busy[1]),
    .otg_hpi_address(haddr[1]), .otg_hpi_cs_n(cs_n[1]), .otg_hpi_r_n(r_n[1]),
    .otg_hpi_w_n(w_n[1]), .otg_hpi_reset_n(hrst_n[1]), .otg_hpi_data_out(dout[1]),
    .otg_hpi_data_oe(oe[1]), .otg_hpi_data_in(din)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %0h, expected %0h (cycle %0d)", nm, d, act, exp, cyc);
    end
  endtask

  function automatic int rec_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  // Model: an operation is described by its kind and its age in cycles since accept.
  bit          m_act[2], m_kind[2], m_pend[2], m_wr[2];
  int          m_age[2], m_own[2], m_last[2];
  logic [1:0]  m_ad[2];
  logic [15:0] m_wd[2], m_cap[2];
  int          k, len, g;
  logic        e_cs, e_rn, e_wn, e_rst, e_oe, e_busy, e_stb;
  logic [1:0]  e_rdy, e_rv;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_act[d] = 0; m_pend[d] = 0; m_last[d] = 1;
        chk("rst_cs_n", d, cs_n[d], 1);   chk("rst_r_n", d, r_n[d], 1);
        chk("rst_w_n", d, w_n[d], 1);     chk("rst_reset_n", d, hrst_n[d], 1);
        chk("rst_oe", d, oe[d], 0);       chk("rst_busy", d, busy[d], 0);
        chk("rst_ready", d, rdy[d], 0);   chk("rst_rsp_valid", d, rv[d], 0);
        chk("rst_addr", d, haddr[d], 0);  chk("rst_dout", d, dout[d], 0);
        chk("rst_rdata", d, rd[d], 0);
      end else begin
        e_cs = 1; e_rn = 1; e_wn = 1; e_rst = 1; e_oe = 0; e_busy = 0;
        e_rdy = '0; e_rv = '0; len = 0; g = 0; k = m_age[d];
        if (m_act[d]) begin
          e_busy = 1;
          if (!m_kind[d]) begin
            len   = S + T + H + rec_of(d);
            e_cs  = !(k < S + T + H);
            e_stb = (k >= S) && (k < S + T);
            e_rn  = !(e_stb && !m_wr[d]);
            e_wn  = !(e_stb && m_wr[d]);
            e_oe  = m_wr[d] && (k < S + T + H);
            e_rv  = (k == S + T) ? (2'b01 << m_own[d]) : 2'b00;
          end else begin
            len   = RSTC + rec_of(d);
            e_rst = !(k < RSTC);
          end
        end else begin
          g = (v[d][0] && v[d][1]) ? (1 - m_last[d]) : (v[d][1] ? 1 : 0);
          if (!m_pend[d] && !crst[d] && v[d] != 2'b00) e_rdy = 2'b01 << g;
        end
        chk("ready", d, rdy[d], e_rdy);   chk("busy", d, busy[d], e_busy);
        chk("cs_n", d, cs_n[d], e_cs);    chk("r_n", d, r_n[d], e_rn);
        chk("w_n", d, w_n[d], e_wn);      chk("reset_n", d, hrst_n[d], e_rst);
        chk("data_oe", d, oe[d], e_oe);   chk("rsp_valid", d, rv[d], e_rv);
        if (!e_cs)          chk("address", d, haddr[d], m_ad[d]);
        if (e_oe)           chk("data_out", d, dout[d], m_wd[d]);
        if (e_rv != 2'b00)  chk("rsp_rdata", d, rd[d], m_wr[d] ? 16'h0 : m_cap[d]);
        if (m_act[d]) begin
          if (!m_kind[d] && k == S + T - 1) m_cap[d] = din;
          if (crst[d]) m_pend[d] = 1;
          m_age[d]++;
          if (m_age[d] == len) m_act[d] = 0;
        end else if (m_pend[d] || crst[d]) begin
          m_act[d] = 1; m_kind[d] = 1; m_age[d] = 0; m_pend[d] = 0;
        end else if (e_rdy != 2'b00) begin
          m_act[d] = 1; m_kind[d] = 0; m_age[d] = 0; m_own[d] = g; m_last[d] = g;
          m_wr[d] = wr[d][g]; m_ad[d] = ad[d][g]; m_wd[d] = wd[d][g];
        end
      end
    end
  end

  int         c_cs, c_wn, c_rn, c_oe, c_rst;
  logic [1:0] c_rsp;
  logic [15:0] c_rd, c_dout;

  task automatic issue(input int d, input int r, input logic w, input logic [1:0] a, input logic [15:0] dat);
    int n;
    v[d][r] = 1'b1; wr[d][r] = w; ad[d][r] = a; wd[d][r] = dat;
    n = 0;
    do begin @(negedge clk); n++; end while (!rdy[d][r] && n < 50);
    chk("accept", d, {31'd0, rdy[d][r]}, 32'd1);
    @(posedge clk); #1;
    v[d][r] = 1'b0;
  endtask

  task automatic watch(input int d, input int n, input int pulse_at);
    c_cs = 0; c_wn = 0; c_rn = 0; c_oe = 0; c_rst = 0; c_rsp = '0; c_rd = '0; c_dout = '0;
    for (int i = 0; i < n; i++) begin
      crst[d] = (i == pulse_at);
      @(negedge clk);
      if (!cs_n[d])   c_cs++;
      if (!w_n[d])    c_wn++;
      if (!r_n[d])    c_rn++;
      if (oe[d])      begin c_oe++; c_dout = dout[d]; end
      if (!hrst_n[d]) c_rst++;
      if (rv[d] != 2'b00) begin c_rsp = c_rsp | rv[d]; c_rd = rd[d]; end
      @(posedge clk); #1;
    end
    crst[d] = 1'b0;
  endtask

  int         acc_cyc[2][4], acc_own[2][4], nacc[2];
  logic [1:0] hs[2];

  initial begin
    rst_n = 1'b0; v = '0; wr = '0; ad = '0; wd = '0; crst = '0; din = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Write from requester 0
    issue(0, 0, 1'b1, HPI_ADDR, 16'h1234);
    watch(0, 12, -1);
    chk("wr_cs_low", 0, c_cs, 5);  chk("wr_w_low", 0, c_wn, 3);
    chk("wr_r_low", 0, c_rn, 0);   chk("wr_oe_cyc", 0, c_oe, 5);
    chk("wr_rsp", 0, c_rsp, 2'b01); chk("wr_dout", 0, c_dout, 16'h1234);
    chk("wr_rdata", 0, c_rd, 16'h0);

    // Read from requester 1, chip reset requested mid-strobe
    din = 16'hBEEF;
    issue(0, 1, 1'b0, HPI_DATA, 16'h0);
    watch(0, 40, 2);
    chk("rd_rsp", 0, c_rsp, 2'b10);  chk("rd_rdata", 0, c_rd, 16'hBEEF);
    chk("rd_w_low", 0, c_wn, 0);     chk("rd_r_low", 0, c_rn, 3);
    chk("rd_cs_low", 0, c_cs, 5);    chk("chiprst_low", 0, c_rst, 16);
    chk("chiprst_idle", 0, busy[0], 0);

    // Both requesters continuously valid on both instances
    nacc[0] = 0; nacc[1] = 0;
    v[0] = 2'b11; v[1] = 2'b11; wr[0] = 2'b01; wr[1] = 2'b10;
    wd[0] = {16'h5555, 16'hAAAA}; wd[1] = {16'h0F0F, 16'hF0F0};
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++)
        if ((v[d] & rdy[d]) != 2'b00 && nacc[d] < 4) begin
          acc_cyc[d][nacc[d]] = cyc;
          acc_own[d][nacc[d]] = rdy[d][1] ? 1 : 0;
          nacc[d]++;
        end
      @(posedge clk); #1;
    end
    v = '0;
    for (int d = 0; d < 2; d++) begin
      chk("rr_accepts", d, nacc[d], 4);
      for (int j = 0; j < 4; j++) begin
        if (j < nacc[d]) chk("rr_owner", d, acc_own[d][j], j & 1);
        if (j > 0 && j < nacc[d]) chk("rr_spacing", d, acc_cyc[d][j] - acc_cyc[d][j-1], (d == 0) ? 8 : 6);
      end
    end
    repeat (10) @(posedge clk);
    #1;

    // Async reset during the write strobe
    issue(0, 0, 1'b1, HPI_MAILBOX, 16'hA5A5);
    @(posedge clk); #1;
    chk("pre_rst_w_n", 0, w_n[0], 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cs_n", 0, cs_n[0], 1); chk("arst_w_n", 0, w_n[0], 1);
    chk("arst_r_n", 0, r_n[0], 1);   chk("arst_oe", 0, oe[0], 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    watch(0, 12, -1);
    chk("arst_no_rsp", 0, c_rsp, 2'b00); chk("arst_no_cs", 0, c_cs, 0);

    // Random traffic on both instances
    hs[0] = '0; hs[1] = '0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) hs[d] = v[d] & rdy[d];
      @(posedge clk); #1;
      din = 16'($urandom);
      for (int d = 0; d < 2; d++) begin
        crst[d] = ($urandom_range(0, 39) == 0);
        for (int r = 0; r < 2; r++) begin
          if (hs[d][r]) v[d][r] = 1'b0;
          if (!v[d][r] && $urandom_range(0, 2) == 0) begin
            v[d][r]  = 1'b1;
            wr[d][r] = 1'($urandom_range(0, 1));
            ad[d][r] = 2'($urandom_range(0, 3));
            wd[d][r] = 16'($urandom);
          end
        end
      end
    end
    v = '0; crst = '0;
    repeat (30) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
